// File: rtl/carbon_arch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carbon_arch_pkg
// Description : Shared CarbonZ480 architecture definitions.
//               - Tier constants P0 (i8080) .. P7 (Z480)
//               - Core-id constants
//               - Boot-script opcode enum
//               - Tier -> core mapping function
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package carbon_arch_pkg;

    // Tier encoding, 8 bits wide
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P0_I8080 = 8'd0;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P1       = 8'd1;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P2       = 8'd2;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P3       = 8'd3;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P4       = 8'd4;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P5       = 8'd5;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P6       = 8'd6;
    localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P7_Z480  = 8'd7;

    // Core identifiers
    localparam logic [1:0] CARBON_CORE_ID_0 = 2'd0;  // P0-P1
    localparam logic [1:0] CARBON_CORE_ID_1 = 2'd1;  // P2-P3
    localparam logic [1:0] CARBON_CORE_ID_2 = 2'd2;  // P4-P6
    localparam logic [1:0] CARBON_CORE_ID_3 = 2'd3;  // P7

    // Boot-script opcodes, held in bits [15:12] of a script word
    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_WAIT     = 4'h1,
        OP_MODEUP   = 4'h2,
        OP_WRSIG    = 4'h3,
        OP_POWEROFF = 4'h4,
        OP_HALT     = 4'hF
    } script_op_e;

    // Core that hosts a given tier
    function automatic logic [1:0] tier_to_core(input logic [7:0] tier);
        logic [1:0] core;
        if (tier <= CARBON_Z80_DERIVED_TIER_P1) begin
            core = CARBON_CORE_ID_0;
        end else if (tier <= CARBON_Z80_DERIVED_TIER_P3) begin
            core = CARBON_CORE_ID_1;
        end else if (tier <= CARBON_Z80_DERIVED_TIER_P6) begin
            core = CARBON_CORE_ID_2;
        end else begin
            core = CARBON_CORE_ID_3;
        end
        return core;
    endfunction

endpackage : carbon_arch_pkg
`default_nettype wire

// File: rtl/carbon_z480_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : carbon_z480_mode_ctrl
// Description : Tier/core state holder for CarbonZ480. Checks MODEUP
//               legality and times the handoff between cores.
// Ports       : clk       in   system clock
//               rst       in   synchronous active-high reset
//               req_i     in   one-cycle MODEUP request strobe
//               target_i  in   requested tier (12-bit script argument)
//               busy_o    out  handoff in progress
//               fault_o   out  sticky illegal-MODEUP flag
//               tier_o    out  active tier
//               core_o    out  active core
// Revision    : 1.0 - initial release
// ============================================================================
module carbon_z480_mode_ctrl
    import carbon_arch_pkg::*;
#(
    parameter int MODE_SWITCH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [11:0] target_i,
    output logic        busy_o,
    output logic        fault_o,
    output logic [7:0]  tier_o,
    output logic [1:0]  core_o
);

    localparam logic [15:0] c_SWITCH_LEN = 16'(MODE_SWITCH_CYCLES);

    logic [7:0]  tier_q;
    logic [1:0]  core_q;
    logic        busy_q;
    logic        fault_q;
    logic [15:0] cnt_q;
    logic [7:0]  pend_tier_q;
    logic        w_legal;

    // Only strictly upward moves inside the tier range are allowed.
    assign w_legal = (target_i <= {4'd0, CARBON_Z80_DERIVED_TIER_P7_Z480}) &&
                     (target_i >  {4'd0, tier_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            tier_q      <= CARBON_Z80_DERIVED_TIER_P0_I8080;
            core_q      <= CARBON_CORE_ID_0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= 16'd0;
            pend_tier_q <= 8'd0;
        end else if (busy_q) begin
            // Tier and core keep their old values for the whole handoff,
            // then both switch on the same edge.
            if (cnt_q <= 16'd1) begin
                tier_q <= pend_tier_q;
                core_q <= tier_to_core(pend_tier_q);
                busy_q <= 1'b0;
                cnt_q  <= 16'd0;
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end else if (req_i) begin
            if (!w_legal) begin
                fault_q <= 1'b1;
            end else if (c_SWITCH_LEN == 16'd0) begin
                tier_q <= target_i[7:0];
                core_q <= tier_to_core(target_i[7:0]);
            end else begin
                busy_q      <= 1'b1;
                cnt_q       <= c_SWITCH_LEN;
                pend_tier_q <= target_i[7:0];
            end
        end
    end

    assign busy_o  = busy_q;
    assign fault_o = fault_q;
    assign tier_o  = tier_q;
    assign core_o  = core_q;

endmodule : carbon_z480_mode_ctrl
`default_nettype wire

// File: rtl/carbon_z480_top.sv
`default_nettype none
// ============================================================================
// Module      : carbon_z480_top
// Description : CarbonZ480 scripted-boot system top. Comes up in tier P0,
//               runs a fixed boot script (wait, MODEUP, write "Z480"
//               signature, poweroff) and halts.
// Ports       : clk        in   system clock
//               rst        in   synchronous active-high reset
//               signature  out  32-bit signature register, byte 0 in [7:0]
//               poweroff   out  sticky poweroff request
// Revision    : 1.0 - initial release
// ============================================================================
module carbon_z480_top
    import carbon_arch_pkg::*;
#(
    parameter int BOOT_WAIT          = 16,
    parameter int MODE_SWITCH_CYCLES = 8,
    parameter int TARGET_TIER        = 7
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] signature,
    output logic        poweroff
);

    // Sequencer states
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_EXEC    = 3'd2;
    localparam logic [2:0] c_ST_WAITCNT = 3'd3;
    localparam logic [2:0] c_ST_SWITCH  = 3'd4;
    localparam logic [2:0] c_ST_HALT    = 3'd5;

    // Probe points for benches
    logic [7:0]  host_active_tier;
    logic [1:0]  host_active_core;

    logic [2:0]  state_q, state_d;
    logic [2:0]  pc_q;
    logic [15:0] instr_q;
    logic [11:0] wait_cnt_q;
    logic [7:0]  modeup_arg_q;
    logic [31:0] sig_q;
    logic        poweroff_q;

    logic [3:0]  w_op;
    logic [11:0] w_arg;
    logic        w_fetch_en;
    logic        w_mode_req;
    logic        w_wait_load;
    logic        w_sig_wr;
    logic        w_po_set;
    logic        w_fault_take;
    logic        w_mode_busy;
    logic        w_mode_fault;

    // Boot script ROM
    function automatic logic [15:0] rom_word(input logic [2:0] addr);
        logic [15:0] word;
        case (addr)
            3'd0:    word = {OP_WAIT,     12'(BOOT_WAIT)};
            3'd1:    word = {OP_MODEUP,   12'(TARGET_TIER)};
            3'd2:    word = {OP_WRSIG,    2'b00, 2'd0, 8'h5A};
            3'd3:    word = {OP_WRSIG,    2'b00, 2'd1, 8'h34};
            3'd4:    word = {OP_WRSIG,    2'b00, 2'd2, 8'h38};
            3'd5:    word = {OP_WRSIG,    2'b00, 2'd3, 8'h30};
            3'd6:    word = {OP_POWEROFF, 12'h000};
            default: word = {OP_HALT,     12'h000};
        endcase
        return word;
    endfunction

    assign w_op  = instr_q[15:12];
    assign w_arg = instr_q[11:0];

    carbon_z480_mode_ctrl #(
        .MODE_SWITCH_CYCLES (MODE_SWITCH_CYCLES)
    ) u_mode_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req_i    (w_mode_req),
        .target_i (w_arg),
        .busy_o   (w_mode_busy),
        .fault_o  (w_mode_fault),
        .tier_o   (host_active_tier),
        .core_o   (host_active_core)
    );

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state. instr_q always holds the op being executed
    // in EXEC; the following op is prefetched alongside, so after WAIT or
    // a handoff the sequencer returns straight to EXEC.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  state_d = c_ST_FETCH;
            c_ST_FETCH: state_d = c_ST_EXEC;
            c_ST_EXEC: begin
                case (w_op)
                    OP_WAIT:   state_d = (w_arg == 12'd0) ? c_ST_EXEC : c_ST_WAITCNT;
                    OP_MODEUP: state_d = c_ST_SWITCH;
                    OP_HALT:   state_d = c_ST_HALT;
                    default:   state_d = c_ST_EXEC;
                endcase
            end
            c_ST_WAITCNT: begin
                if (wait_cnt_q <= 12'd1) begin
                    state_d = c_ST_EXEC;
                end
            end
            c_ST_SWITCH: begin
                if (w_mode_fault) begin
                    state_d = c_ST_HALT;
                end else if (!w_mode_busy) begin
                    state_d = c_ST_EXEC;
                end
            end
            c_ST_HALT:  state_d = c_ST_HALT;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_en   = 1'b0;
        w_mode_req   = 1'b0;
        w_wait_load  = 1'b0;
        w_sig_wr     = 1'b0;
        w_po_set     = 1'b0;
        w_fault_take = 1'b0;
        case (state_q)
            c_ST_FETCH: w_fetch_en = 1'b1;
            c_ST_EXEC: begin
                w_fetch_en  = (w_op != OP_HALT);
                w_mode_req  = (w_op == OP_MODEUP);
                w_wait_load = (w_op == OP_WAIT);
                // Signature is frozen once poweroff has been requested.
                w_sig_wr    = (w_op == OP_WRSIG) && !poweroff_q;
                w_po_set    = (w_op == OP_POWEROFF);
            end
            c_ST_SWITCH: w_fault_take = w_mode_fault;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: PC, instruction, wait counter, signature, poweroff
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= 3'd0;
            instr_q      <= 16'h0000;
            wait_cnt_q   <= 12'd0;
            modeup_arg_q <= 8'h00;
            sig_q        <= 32'h0000_0000;
            poweroff_q   <= 1'b0;
        end else begin
            if (w_fetch_en) begin
                instr_q <= rom_word(pc_q);
                pc_q    <= pc_q + 3'd1;
            end

            if (w_wait_load) begin
                wait_cnt_q <= w_arg;
            end else if ((state_q == c_ST_WAITCNT) && (wait_cnt_q != 12'd0)) begin
                wait_cnt_q <= wait_cnt_q - 12'd1;
            end

            // The MODEUP word is gone from instr_q once the next op is
            // prefetched, so its argument is kept for the fault signature.
            if (w_mode_req) begin
                modeup_arg_q <= w_arg[7:0];
            end

            if (w_fault_take) begin
                sig_q      <= {16'hDEAD, 8'h00, modeup_arg_q};
                poweroff_q <= 1'b1;
            end else begin
                if (w_sig_wr) begin
                    sig_q[{w_arg[9:8], 3'b000} +: 8] <= w_arg[7:0];
                end
                if (w_po_set) begin
                    poweroff_q <= 1'b1;
                end
            end
        end
    end

    assign signature = sig_q;
    assign poweroff  = poweroff_q;

endmodule : carbon_z480_top
`default_nettype wire

// File: tb/tb_carbon_z480_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_carbon_z480_top
// Description : Self-checking bench for carbon_z480_top. Three instances
//               (TARGET_TIER 7, 0 and 4) share clock and reset; reset
//               lengths and mid-run reset points are randomized, and
//               results are compared with a script-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carbon_z480_top;

    typedef struct packed {
        logic [31:0] sig;
        logic [7:0]  tier;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sig7, sig0, sig4;
    logic        po7, po0, po4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    carbon_z480_top dut (
        .clk       (clk),
        .rst       (rst),
        .signature (sig7),
        .poweroff  (po7)
    );

    carbon_z480_top #(.TARGET_TIER(0)) dut_t0 (
        .clk       (clk),
        .rst       (rst),
        .signature (sig0),
        .poweroff  (po0)
    );

    carbon_z480_top #(.TARGET_TIER(4)) dut_t4 (
        .clk       (clk),
        .rst       (rst),
        .signature (sig4),
        .poweroff  (po4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core map from tier ranges
    function automatic logic [1:0] ref_core(input int t);
        if (t < 2) return 2'd0;
        if (t < 4) return 2'd1;
        if (t < 7) return 2'd2;
        return 2'd3;
    endfunction

    // End state of the boot script for a given MODEUP target, starting at P0
    function automatic ref_t ref_final(input int tgt);
        ref_t r;
        logic [7:0] lane_data [4];
        lane_data[0] = 8'h5A;
        lane_data[1] = 8'h34;
        lane_data[2] = 8'h38;
        lane_data[3] = 8'h30;
        if (tgt >= 1 && tgt <= 7) begin
            r.tier = 8'(tgt);
            r.sig  = 32'h0;
            for (int i = 0; i < 4; i++) begin
                r.sig[8*i +: 8] = lane_data[i];
            end
        end else begin
            r.tier = 8'd0;
            r.sig  = {16'hDEAD, 8'h00, 8'(tgt)};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/tier"},  {24'd0, dut.host_active_tier}, 32'd0);
        check({tag, "/core"},  {30'd0, dut.host_active_core}, 32'd0);
        check({tag, "/sig"},   sig7, 32'd0);
        check({tag, "/po"},    {31'd0, po7}, 32'd0);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        check_reset_state(tag);
    endtask

    // Run until every instance requests poweroff, checking per-cycle
    // invariants, then compare final state against the model.
    task automatic run_sequence(input string tag);
        int   cyc      = 0;
        int   tier_cyc = -1;
        int   po_cyc   = -1;
        int   bad      = 0;
        int   unstable = 0;
        int   t7, t0, t4;
        ref_t r7, r0, r4;
        r7 = ref_final(7);
        r0 = ref_final(0);
        r4 = ref_final(4);
        while (cyc < 2000 && !(po7 && po0 && po4)) begin
            tick();
            cyc++;
            t7 = int'(dut.host_active_tier);
            t0 = int'(dut_t0.host_active_tier);
            t4 = int'(dut_t4.host_active_tier);
            if (tier_cyc < 0 && t7 != 0) tier_cyc = cyc;
            if (po_cyc < 0 && po7) po_cyc = cyc;
            if (!(t7 == 0 || t7 == 7)) bad++;
            if (dut.host_active_core != ref_core(t7)) bad++;
            if (t0 != 0 || dut_t0.host_active_core != 2'd0) bad++;
            if (!(t4 == 0 || t4 == 4)) bad++;
            if (dut_t4.host_active_core != ref_core(t4)) bad++;
        end
        check({tag, "/tier_in_time"}, {31'd0, (tier_cyc > 0 && tier_cyc < 40)}, 32'd1);
        check({tag, "/po_after_tier"},
              {31'd0, (po_cyc >= tier_cyc && tier_cyc > 0 && (po_cyc - tier_cyc) <= 10)}, 32'd1);
        check({tag, "/invariants"}, 32'(bad), 32'd0);
        check({tag, "/t7_sig"},  sig7, r7.sig);
        check({tag, "/t7_tier"}, {24'd0, dut.host_active_tier}, {24'd0, r7.tier});
        check({tag, "/t7_core"}, {30'd0, dut.host_active_core}, {30'd0, ref_core(int'(r7.tier))});
        check({tag, "/t7_po"},   {31'd0, po7}, 32'd1);
        check({tag, "/t0_sig"},  sig0, r0.sig);
        check({tag, "/t0_tier"}, {24'd0, dut_t0.host_active_tier}, {24'd0, r0.tier});
        check({tag, "/t0_po"},   {31'd0, po0}, 32'd1);
        check({tag, "/t4_sig"},  sig4, r4.sig);
        check({tag, "/t4_tier"}, {24'd0, dut_t4.host_active_tier}, {24'd0, r4.tier});
        check({tag, "/t4_core"}, {30'd0, dut_t4.host_active_core}, {30'd0, ref_core(int'(r4.tier))});
        repeat ($urandom_range(5, 30)) begin
            tick();
            if (sig7 !== r7.sig || po7 !== 1'b1) unstable++;
            if (sig0 !== r0.sig || sig4 !== r4.sig) unstable++;
        end
        check({tag, "/held_after_po"}, 32'(unstable), 32'd0);
    endtask

    initial begin
        int waited;
        logic was_busy;

        // Long initial reset, then the full default run
        do_reset(10, "rst0");
        run_sequence("run0");

        // Reset pulse while the default instance is mid-handoff
        do_reset(int'($urandom_range(1, 4)), "rst1");
        waited = 0;
        while (!dut.u_mode_ctrl.busy_o && waited < 100) begin
            tick();
            waited++;
        end
        check("switch_reached", {31'd0, dut.u_mode_ctrl.busy_o}, 32'd1);
        repeat ($urandom_range(0, 5)) tick();
        was_busy = dut.u_mode_ctrl.busy_o;
        check("still_switching", {31'd0, was_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_in_switch");
        run_sequence("after_switch_rst");

        // Resets at random points of the script
        for (int i = 0; i < 3; i++) begin
            do_reset(int'($urandom_range(1, 4)), $sformatf("rst_r%0d", i));
            repeat ($urandom_range(0, 45)) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_state($sformatf("rst_mid%0d", i));
            run_sequence($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_carbon_z480_top
`default_nettype wire
